mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- One transaction is outstanding at a time.
- LSU has fixed priority over IF, and a starvation counter guarantees forward progress for IF.
- A pipeline flush kills an in-flight fetch response.
- Sits between the IF/MEM pipeline stages and the bus bridge.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (strobe width DATA_W/8)
STARVE_LIMIT, 4, consecutive LSU grants with IF pending before IF is forced to win; 0 = pure LSU priority

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline redirect; kills pending/in-flight IF request
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address
if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
if_rsp_data  out  DATA_W  fetch data
if_rsp_err  out  1  bus error on fetch
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_we  in  1  1 = store
lsu_addr  in  ADDR_W  address
lsu_wdata  in  DATA_W  store data
lsu_wstrb  in  DATA_W/8  byte strobes
lsu_size  in  2  0=B,1=H,2=W,3=D
lsu_rsp_valid  out  1  load data / store ack (1-cycle pulse)
lsu_rsp_data  out  DATA_W  load data
lsu_rsp_err  out  1  bus error
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts request
mem_we, mem_addr, mem_wdata, mem_wstrb, mem_size  out  as LSU  latched request fields
mem_rsp_valid  in  1  downstream response
mem_rsp_data  in  DATA_W  response data
mem_rsp_err  in  1  response error
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=LSU, kill=0, starve_cnt=0.
  - All mem_* request registers are 0; all ready/valid outputs are 0.
- Requesters hold valid and payload stable until ready. Ready is asserted only in IDLE, at most one of the two, for exactly one cycle.
- IDLE:
  - Grant rule: IF wins if if_req_valid & ~flush & (~lsu_req_valid | (STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT)). Otherwise LSU wins if lsu_req_valid.
  - On grant: assert the winner's req_ready (combinational), latch the payload into mem_* registers (IF: we=0, size=3, wstrb=0, wdata=0), record owner, go REQ.
- REQ: mem_req_valid=1 and the payload is held. On mem_req_ready go RESP.
- RESP:
  - Wait for mem_rsp_valid.
  - Response is routed combinationally in the same cycle: owner's rsp_valid = mem_rsp_valid, and rsp_data/rsp_err pass through.
  - The non-owner's rsp_data reads 0.
  - Then go IDLE.
- Latency: accept at cycle T, mem_req_valid from T+1. With zero-wait memory the response arrives at T+2 and the next accept is at T+3.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on an LSU grant while if_req_valid.
  - Cleared on IF grant.
  - Held otherwise.
- Flush:
  - In IDLE: IF is not granted that cycle.
  - In REQ/RESP with owner=IF: set kill. The bus transaction still completes (no mid-handshake abort), but if_rsp_valid is suppressed.
  - flush in the same cycle as the IF mem_rsp_valid also suppresses the response.
  - kill clears on return to IDLE.
  - Flush never affects LSU transactions.
- mem_rsp_valid outside RESP is ignored. mem_req_ready outside REQ is ignored.
- Reset mid-transaction returns immediately to IDLE. The downstream is reset by the same rst_n.

Decomposition:
- Shared defines file: arbiter state encodings (IDLE/REQ/RESP), owner encoding, size encodings (shared with the LSU).
- No sub-module. The starvation counter and the FSM are small enough to stay inline.

Test Plan:
- IF only, addr 0x8000_0000, mem ready same cycle, rsp one cycle later with data 0x0000_0013_0000_0013 -> if_req_ready at T, mem_req_valid at T+1, if_rsp_valid at T+2 with that data, busy low at T+3.
- IF and LSU valid together, LSU store to 0x8000_1000, wstrb 0xFF -> LSU granted first with mem_we=1; IF granted on the next IDLE cycle.
- LSU valid continuously with IF pending, STARVE_LIMIT=4 -> exactly 4 LSU grants, then the 5th grant goes to IF; starve_cnt returns to 0.
- IF granted, flush pulsed in RESP before mem_rsp_valid -> if_rsp_valid stays 0 and FSM returns to IDLE after the response. With flush and IF valid in IDLE, the LSU request is granted instead.
- mem_req_ready held low 10 cycles -> mem_req_valid and payload stable for all 10 cycles; mem_rsp_err=1 on an LSU load -> lsu_rsp_err=1 with lsu_rsp_valid.
- rst_n asserted in RESP -> all outputs 0 and state IDLE asynchronously; a new request is accepted in the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Summary  : Shared encodings for the memory-port arbiter and the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_LSU = 1'b0,
    OWNER_IF  = 1'b1
  } arb_owner_t;

  localparam logic [1:0] c_SIZE_B = 2'd0;
  localparam logic [1:0] c_SIZE_H = 2'd1;
  localparam logic [1:0] c_SIZE_W = 2'd2;
  localparam logic [1:0] c_SIZE_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Summary  : Shares one memory port between instruction fetch and the LSU,
//            one transaction outstanding, LSU priority with IF anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic                if_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic [1:0]          lsu_size,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [1:0]          mem_size,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic                busy
);

  localparam int c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
  localparam logic c_STARVE_EN = (STARVE_LIMIT != 0);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  arb_owner_t         r_owner;
  logic               r_kill;
  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               w_if_win;
  logic               w_lsu_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_if_win      = 1'b0;
    w_lsu_win     = 1'b0;
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = '0;
    if_rsp_err    = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = '0;
    lsu_rsp_err   = 1'b0;
    busy          = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        // rst_n gating keeps both readies low while reset is held
        w_if_win  = rst_n & if_req_valid & ~flush &
                    (~lsu_req_valid | (c_STARVE_EN & (r_starve_cnt == c_LIMIT)));
        w_lsu_win = rst_n & ~w_if_win & lsu_req_valid;
        if_req_ready  = w_if_win;
        lsu_req_ready = w_lsu_win;
        if (w_if_win || w_lsu_win) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_owner == OWNER_IF) begin
          // a flush landing on the response cycle kills it as well
          if_rsp_valid = mem_rsp_valid & ~r_kill & ~flush;
          if_rsp_data  = mem_rsp_data;
          if_rsp_err   = if_rsp_valid & mem_rsp_err;
        end else begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rsp_data  = mem_rsp_data;
          lsu_rsp_err   = mem_rsp_valid & mem_rsp_err;
        end
        if (mem_rsp_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWNER_LSU;
      r_kill       <= 1'b0;
      r_starve_cnt <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      mem_size     <= 2'd0;
    end else begin
      if (w_if_win) begin
        r_owner      <= OWNER_IF;
        r_starve_cnt <= '0;
        mem_we       <= 1'b0;
        mem_addr     <= if_addr;
        mem_wdata    <= '0;
        mem_wstrb    <= '0;
        mem_size     <= c_SIZE_D;
      end else if (w_lsu_win) begin
        r_owner   <= OWNER_LSU;
        mem_we    <= lsu_we;
        mem_addr  <= lsu_addr;
        mem_wdata <= lsu_wdata;
        mem_wstrb <= lsu_wstrb;
        mem_size  <= lsu_size;
        if (if_req_valid && (r_starve_cnt != c_LIMIT)) begin
          r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
        end
      end

      // the bus transaction still completes; only the IF response is dropped
      if (r_state == ST_IDLE) begin
        r_kill <= 1'b0;
      end else if (flush && (r_owner == OWNER_IF)) begin
        r_kill <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Summary  : Scoreboard bench for mem_port_arbiter with a scripted memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        if_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic [1:0]  lsu_size;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [1:0]  mem_size;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .busy(busy)
  );

  typedef struct { bit is_if; logic [63:0] data; bit err; } exp_t;
  typedef struct { logic [63:0] data; bit err; } mrsp_t;

  exp_t  exp_q[$];
  mrsp_t mem_q[$];
  bit    grant_log[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    wait_cfg = 0;
  int    rsp_delay_cfg = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scripted downstream: ready after wait_cfg cycles, response rsp_delay_cfg later
  initial begin
    int    phase;
    int    wcnt;
    int    dcnt;
    mrsp_t cur;
    phase = 0; wcnt = 0; dcnt = 0;
    cur = '{64'd0, 1'b0};
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      if (!rst_n) begin
        mem_req_ready = 1'b0; phase = 0; wcnt = 0;
      end else if (phase == 0) begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (wcnt < wait_cfg) begin
            wcnt++;
          end else begin
            mem_req_ready = 1'b1;
            phase = 1; dcnt = 0;
            cur = (mem_q.size() != 0) ? mem_q.pop_front() : '{64'd0, 1'b0};
          end
        end
      end else begin
        mem_req_ready = 1'b0;
        if (dcnt < rsp_delay_cfg) begin
          dcnt++;
        end else begin
          mem_rsp_valid = 1'b1; mem_rsp_data = cur.data; mem_rsp_err = cur.err;
          phase = 0; wcnt = 0;
        end
      end
    end
  end

  // Monitor: every response pulse must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && (if_rsp_valid || lsu_rsp_valid)) begin
        check("rsp_exclusive", {63'd0, if_rsp_valid & lsu_rsp_valid}, 64'd0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got if=%0b lsu=%0b expected none", if_rsp_valid, lsu_rsp_valid);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", {63'd0, if_rsp_valid}, {63'd0, e.is_if});
          check("rsp_data", e.is_if ? if_rsp_data : lsu_rsp_data, e.data);
          check("rsp_err", {63'd0, e.is_if ? if_rsp_err : lsu_rsp_err}, {63'd0, e.err});
          check("rsp_other_zero", e.is_if ? lsu_rsp_data : if_rsp_data, 64'd0);
        end
      end
    end
  end

  task automatic do_if(input logic [63:0] addr, input logic [63:0] data, input bit err,
                       input bit expect_rsp);
    int budget;
    @(negedge clk);
    if_addr = addr; if_req_valid = 1'b1; #1;
    budget = 0;
    while (!if_req_ready && budget < 200) begin
      @(negedge clk); #1; budget++;
    end
    if (!if_req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL if_grant_timeout: got no ready expected ready");
    end else begin
      grant_log.push_back(1'b1);
      mem_q.push_back('{data, err});
      if (expect_rsp) exp_q.push_back('{1'b1, data, err});
    end
    @(negedge clk);
    if_req_valid = 1'b0;
  endtask

  task automatic do_lsu(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb, input logic [1:0] size,
                        input logic [63:0] rdata, input bit err);
    int budget;
    @(negedge clk);
    lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_wstrb = strb; lsu_size = size;
    lsu_req_valid = 1'b1; #1;
    budget = 0;
    while (!lsu_req_ready && budget < 200) begin
      @(negedge clk); #1; budget++;
    end
    if (!lsu_req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL lsu_grant_timeout: got no ready expected ready");
    end else begin
      grant_log.push_back(1'b0);
      mem_q.push_back('{rdata, err});
      exp_q.push_back('{1'b0, rdata, err});
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk); #1;
    while ((busy || exp_q.size() != 0) && budget < 100) begin
      @(negedge clk); #1; budget++;
    end
    if (busy || exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  initial begin
    logic [5:0] starve_seq;
    int         cnt;
    rst_n = 1'b0; flush = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    lsu_wstrb = '0; lsu_size = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_size", {62'd0, mem_size}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IF alone, zero-wait memory: ready T, req T+1, rsp T+2, idle T+3
    do_if(64'h8000_0000, 64'h0000_0013_0000_0013, 1'b0, 1'b1);
    #1;
    check("t1_req_valid", {63'd0, mem_req_valid}, 64'd1);
    check("t1_mem_addr", mem_addr, 64'h8000_0000);
    check("t1_mem_size", {62'd0, mem_size}, 64'd3);
    check("t1_mem_we", {63'd0, mem_we}, 64'd0);
    @(negedge clk); #1;
    check("t1_rsp_valid", {63'd0, if_rsp_valid}, 64'd1);
    @(negedge clk); #1;
    check("t1_busy_low", {63'd0, busy}, 64'd0);

    // Simultaneous requests: LSU store first, IF next
    grant_log.delete();
    fork
      begin
        do_lsu(1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 2'd3, 64'd0, 1'b0);
        #1;
        check("t2_mem_we", {63'd0, mem_we}, 64'd1);
        check("t2_mem_addr", mem_addr, 64'h8000_1000);
        check("t2_mem_wstrb", {56'd0, mem_wstrb}, 64'hFF);
      end
      do_if(64'h8000_0008, 64'h0000_0000_0000_0113, 1'b0, 1'b1);
    join
    wait_idle();
    check("t2_order_len", grant_log.size(), 64'd2);
    if (grant_log.size() == 2) begin
      check("t2_first_lsu", {63'd0, grant_log[0]}, 64'd0);
      check("t2_second_if", {63'd0, grant_log[1]}, 64'd1);
    end

    // Continuous LSU with IF pending: 4 LSU grants, then IF
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 5; i++)
          do_lsu(1'b0, 64'h8000_2000 + 64'(8 * i), 64'd0, 8'h00, 2'd3, 64'hA0 + 64'(i), 1'b0);
      end
      do_if(64'h8000_0080, 64'h0000_0000_0000_00B0, 1'b0, 1'b1);
    join
    wait_idle();
    starve_seq = 6'b010000;
    check("t3_order_len", grant_log.size(), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size())
        check($sformatf("t3_grant%0d", i), {63'd0, grant_log[i]}, {63'd0, starve_seq[i]});
    end
    check("t3_starve_cnt", {61'd0, dut.r_starve_cnt}, 64'd0);

    // Flush in RESP before the response
    rsp_delay_cfg = 2;
    do_if(64'h8000_0100, 64'hDEAD_0001, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rsp_delay_cfg = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (if_rsp_valid) cnt++;
    end
    check("t4_killed_rsp", cnt, 64'd0);
    check("t4_idle", {63'd0, busy}, 64'd0);

    // Flush coincident with the response cycle
    do_if(64'h8000_0140, 64'hDEAD_0002, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1; #1;
    check("t4b_same_cycle", {63'd0, if_rsp_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    wait_idle();

    // Flush in IDLE with both requesting: LSU wins
    @(negedge clk);
    flush = 1'b1; if_addr = 64'h8000_0180; if_req_valid = 1'b1;
    lsu_we = 1'b0; lsu_addr = 64'h8000_4000; lsu_size = 2'd2; lsu_req_valid = 1'b1;
    #1;
    check("t4c_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
    check("t4c_if_ready", {63'd0, if_req_ready}, 64'd0);
    if (lsu_req_ready) begin
      mem_q.push_back('{64'h0000_0000_CAFE_F00D, 1'b0});
      exp_q.push_back('{1'b0, 64'h0000_0000_CAFE_F00D, 1'b0});
    end
    @(negedge clk);
    lsu_req_valid = 1'b0; flush = 1'b0;
    do_if(64'h8000_0180, 64'h0000_0000_0000_0193, 1'b0, 1'b1);
    wait_idle();

    // Stalled downstream, then an LSU load error
    wait_cfg = 10;
    do_lsu(1'b0, 64'h8000_3000, 64'd0, 8'h00, 2'd3, 64'h0000_0000_0000_DEAD, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!(mem_req_valid && mem_addr == 64'h8000_3000 && !mem_we && mem_size == 2'd3)) cnt++;
      @(negedge clk);
    end
    check("t5_hold_stable", cnt, 64'd0);
    wait_idle();
    wait_cfg = 0;

    // Reset asserted in RESP, then an immediate new request
    rsp_delay_cfg = 5;
    do_if(64'h8000_0200, 64'hBEEF, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("t6_in_resp", {63'd0, busy}, 64'd1);
    rst_n = 1'b0; #1;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("t6_mem_addr", mem_addr, 64'd0);
    check("t6_rsp_valid", {63'd0, if_rsp_valid | lsu_rsp_valid}, 64'd0);
    exp_q.delete(); mem_q.delete();
    rsp_delay_cfg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lsu_we = 1'b1; lsu_addr = 64'h8000_5000; lsu_wdata = 64'h55; lsu_wstrb = 8'h01;
    lsu_size = 2'd0; lsu_req_valid = 1'b1;
    #1;
    check("t6_first_accept", {63'd0, lsu_req_ready}, 64'd1);
    if (lsu_req_ready) begin
      mem_q.push_back('{64'd0, 1'b0});
      exp_q.push_back('{1'b0, 64'd0, 1'b0});
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    wait_idle();

    check("final_queue_empty", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
